// File: rtl/cpu_pkg.sv
// Shared CPU definitions: architectural widths, NZCV flag bit positions and the
// writeback queue entry layout.
package cpu_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
        logic [3:0]        flags;
        logic              flags_en;
    } wb_entry_t;

endpackage

// File: rtl/wb_queue.sv
// In-order FIFO of writeback entries. Every slot is exposed in age order
// (index 0 = head) with a valid bit so the owner can search pending writes.
module wb_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  wb_entry_t                  push_entry,
    input  logic                       pop,
    output wb_entry_t                  head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output wb_entry_t [DEPTH-1:0]      entries,
    output logic [DEPTH-1:0]           valid
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    wb_entry_t        mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    // The extra pointer bit separates full (MSBs differ) from empty (equal).
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[IW] != rd_ptr_reg[IW]) &&
                     (wr_ptr_reg[IW-1:0] == rd_ptr_reg[IW-1:0]);
    assign count   = wr_ptr_reg - rd_ptr_reg;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr_reg[IW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg[IW-1:0]] <= push_entry;
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_view
            logic [IW-1:0] slot;
            assign slot        = rd_ptr_reg[IW-1:0] + IW'(gi);
            assign entries[gi] = mem[slot];
            assign valid[gi]   = (PW'(gi) < count);
        end
    endgenerate

endmodule

// File: rtl/reg_writeback.sv
// Register-file write side: buffers ALU results, drains one per cycle into the
// registered write port, tracks NZCV and forwards pending values to readers.
module reg_writeback
    import cpu_pkg::*;
#(
    parameter int width = XLEN,
    parameter int AW    = REG_AW,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    res_valid,
    output logic                    res_ready,
    input  logic [AW-1:0]           res_rd,
    input  logic [width-1:0]        res_data,
    input  logic [3:0]              res_flags,
    input  logic                    res_flags_en,
    input  logic                    wr_stall,
    output logic                    reg_wr_en,
    output logic [AW-1:0]           write_reg,
    output logic [width-1:0]        reg_wr_data,
    output logic [3:0]              flags_q,
    input  logic [AW-1:0]           fwd_addr1,
    input  logic [AW-1:0]           fwd_addr2,
    output logic                    fwd_hit1,
    output logic                    fwd_hit2,
    output logic [width-1:0]        fwd_data1,
    output logic [width-1:0]        fwd_data2,
    output logic [$clog2(DEPTH):0]  pending
);

    wb_entry_t              new_entry;
    wb_entry_t              head;
    wb_entry_t [DEPTH-1:0]  q_entries;
    logic [DEPTH-1:0]       q_valid;
    logic                   q_full;
    logic                   q_empty;
    logic                   push;
    logic                   pop;

    logic                   wr_en_reg;
    logic [AW-1:0]          wr_reg_reg;
    logic [width-1:0]       wr_data_reg;
    logic [3:0]             flags_reg;

    assign new_entry = '{rd: res_rd, data: res_data, flags: res_flags, flags_en: res_flags_en};
    assign res_ready = !q_full;
    assign push      = res_valid && !q_full;
    assign pop       = !q_empty && !wr_stall;

    wb_queue #(.DEPTH(DEPTH)) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (new_entry),
        .pop        (pop),
        .head       (head),
        .full       (q_full),
        .empty      (q_empty),
        .count      (pending),
        .entries    (q_entries),
        .valid      (q_valid)
    );

    // Writes to x0 are suppressed at the strobe, but their flags still retire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_reg   <= 1'b0;
            wr_reg_reg  <= '0;
            wr_data_reg <= '0;
            flags_reg   <= '0;
        end else if (pop) begin
            wr_en_reg   <= (head.rd != '0);
            wr_reg_reg  <= head.rd;
            wr_data_reg <= head.data;
            if (head.flags_en) flags_reg <= head.flags;
        end else begin
            wr_en_reg   <= 1'b0;
        end
    end

    assign reg_wr_en   = wr_en_reg;
    assign write_reg   = wr_reg_reg;
    assign reg_wr_data = wr_data_reg;
    assign flags_q     = flags_reg;

    logic [AW-1:0]    fwd_addr [2];
    logic [1:0]       fwd_hit;
    logic [width-1:0] fwd_data [2];

    assign fwd_addr[0] = fwd_addr1;
    assign fwd_addr[1] = fwd_addr2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            logic             hit;
            logic [width-1:0] data;
            // Scan oldest to youngest so the last match (queue tail) wins.
            always_comb begin
                hit  = 1'b0;
                data = '0;
                if (wr_en_reg && (wr_reg_reg == fwd_addr[gi])) begin
                    hit  = 1'b1;
                    data = wr_data_reg;
                end
                for (int k = 0; k < DEPTH; k++) begin
                    if (q_valid[k] && (q_entries[k].rd == fwd_addr[gi])) begin
                        hit  = 1'b1;
                        data = q_entries[k].data;
                    end
                end
                if (fwd_addr[gi] == '0) begin
                    hit  = 1'b0;
                    data = '0;
                end
            end
            assign fwd_hit[gi]  = hit;
            assign fwd_data[gi] = data;
        end
    endgenerate

    assign fwd_hit1  = fwd_hit[0];
    assign fwd_hit2  = fwd_hit[1];
    assign fwd_data1 = fwd_data[0];
    assign fwd_data2 = fwd_data[1];

endmodule
